// File: rtl/bcd_digit_serial_ctrl_if.sv
// Operand/result handshake bundle for the digit-serial BCD adder.
// The master drives operands and out_ready; the slave (controller) drives the result side.
interface bcd_digit_serial_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  c_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  c_out;
  logic                  error;
  logic                  busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, error, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, error, busy
  );
endinterface

// File: rtl/bcd_digit_serial_ctrl.sv
// Digit-serial packed-BCD adder: one shared single-digit adder, one digit per clock,
// least-significant digit first, with the carry chained through a register.
module bcd_adder (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout,
  output logic       o_oor
);
  logic [4:0] w_raw;
  logic [4:0] w_adj;

  assign w_raw  = {1'b0, i_x} + {1'b0, i_y} + {4'b0000, i_cin};
  assign w_adj  = w_raw - 5'd10;
  assign o_cout = (w_raw > 5'd9);
  assign o_s    = o_cout ? w_adj[3:0] : w_raw[3:0];
  assign o_oor  = (i_x > 4'd9) | (i_y > 4'd9);
endmodule

module bcd_digit_serial_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  bcd_digit_serial_ctrl_if.slave        bus
);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic [4*DIGITS-1:0] r_sum;
  logic                r_cout;
  logic                r_err;

  logic [4*DIGITS-1:0] w_a_sh;
  logic [4*DIGITS-1:0] w_b_sh;
  logic [3:0]          w_s;
  logic                w_cout;
  logic                w_oor;

  // Select the current digit by shifting the latched operands down by 4*idx.
  assign w_a_sh = r_a >> {r_idx, 2'b00};
  assign w_b_sh = r_b >> {r_idx, 2'b00};

  bcd_adder u_bcd_adder (
    .i_x    (w_a_sh[3:0]),
    .i_y    (w_b_sh[3:0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout),
    .o_oor  (w_oor)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.c_in;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_s;
          r_carry <= w_cout;
          r_err   <= r_err | w_oor;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout;
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_ADD) | (r_state == S_DONE);
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_cout;
  assign bus.error     = r_err;
endmodule
